ttl_mux_scan_sequencer: RTL

//  Upstream/downstream companion to the dual 4-input TTL multiplexer (ttl_74153).

---
 rtl/ttl_mux_scan_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ttl_mux_scan_sequencer.sv
// ttl_mux_scan_sequencer
//   Drives the Select lines of a bank of 74153-style 4:1 mux sections, waits for
//   the mux output to settle, samples each section's Y and assembles the inputs
//   into one parallel word.
//
//   Handshake: valid rises when a complete scan is in data. data and valid hold
//   steady until ready is sampled high on a rising edge while valid=1. That edge
//   completes the transfer. ready is ignored at any other time.
//
//   Optional build macro: MUX_SCAN_DOUBLE_SAMPLE_EN
//     When defined, every position is sampled on two consecutive edges. The first
//     sample is stored. A mismatch on the second sample sets a sticky flag that is
//     reported on glitch together with valid.
//     When undefined, each position is sampled once and glitch is tied low.
//
//   dbg_state exposes the FSM state register so checkers can observe it.
module ttl_mux_scan_sequencer #(
  parameter int BLOCKS        = 2,
  parameter int WIDTH_IN      = 4,
  parameter int WIDTH_SELECT  = $clog2(WIDTH_IN),
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         clear_bar,
  input  logic                         start,
  output logic                         busy,
  output logic [WIDTH_SELECT-1:0]      select,
  output logic [BLOCKS-1:0]            enable_bar,
  input  logic [BLOCKS-1:0]            y,
  output logic [BLOCKS*WIDTH_IN-1:0]   data,
  output logic                         valid,
  input  logic                         ready,
  output logic                         glitch,
  output logic [1:0]                   dbg_state
);

  localparam int DW = BLOCKS * WIDTH_IN;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);
  localparam logic [WIDTH_SELECT-1:0] SEL_MAX = WIDTH_SELECT'(WIDTH_IN - 1);
  localparam logic [WIDTH_SELECT-1:0] SEL_ONE = WIDTH_SELECT'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // With no settle time the drive phase is skipped entirely.
  localparam state_t ST_FIRST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_DRIVE;

  state_t                   state_q, state_d;
  logic [WIDTH_SELECT-1:0]  select_q, select_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [DW-1:0]            shadow_q, shadow_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic [BLOCKS-1:0]        enb_q, enb_d;
  logic [DW-1:0]            merged;
  logic                     launch;
  logic                     advance;

`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
  logic                     phase_q, phase_d;
  logic                     sticky_q, sticky_d;
  logic                     glitch_q, glitch_d;
  logic [BLOCKS-1:0]        stored;
  logic                     mismatch;

  // Bits captured by the first sample of the current position, one per section.
  always_comb begin
    stored = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      for (int i = 0; i < WIDTH_IN; i++) begin
        if (select_q == WIDTH_SELECT'(i)) begin
          stored[b] = shadow_q[b*WIDTH_IN + i];
        end
      end
    end
  end
`endif

  // Shadow word with the current Y bits dropped into the selected positions.
  always_comb begin
    merged = shadow_q;
    for (int b = 0; b < BLOCKS; b++) begin
      for (int i = 0; i < WIDTH_IN; i++) begin
        if (select_q == WIDTH_SELECT'(i)) begin
          merged[b*WIDTH_IN + i] = y[b];
        end
      end
    end
  end

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    enb_d    = enb_q;
    launch   = 1'b0;
    advance  = 1'b0;
`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
    phase_d  = phase_q;
    sticky_d = sticky_q;
    glitch_d = glitch_q;
    mismatch = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        enb_d = '1;
        if (start) begin
          launch = 1'b1;
        end
      end

      ST_DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == SETTLE_L) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
        if (!phase_q) begin
          // First edge: keep this sample as the delivered bit.
          shadow_d = merged;
          phase_d  = 1'b1;
        end else begin
          // Second edge: compare only, then move on.
          phase_d  = 1'b0;
          mismatch = |(y ^ stored);
          sticky_d = sticky_q | mismatch;
          advance  = 1'b1;
        end
`else
        shadow_d = merged;
        advance  = 1'b1;
`endif
      end

      ST_HOLD: begin
        valid_d  = 1'b1;
        enb_d    = '1;
        select_d = '0;
        if (ready) begin
          valid_d = 1'b0;
`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
          glitch_d = 1'b0;
          sticky_d = 1'b0;
`endif
          if (start) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (select_q == SEL_MAX) begin
        // Last position: publish the word; data is untouched at any other time.
        data_d   = shadow_d;
        valid_d  = 1'b1;
        enb_d    = '1;
        select_d = '0;
        state_d  = ST_HOLD;
`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
        glitch_d = sticky_d;
`endif
      end else begin
        select_d = select_q + SEL_ONE;
        cnt_d    = '0;
        state_d  = ST_FIRST;
      end
    end

    if (launch) begin
      state_d  = ST_FIRST;
      select_d = '0;
      cnt_d    = '0;
      enb_d    = '0;
      shadow_d = '0;
`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
      phase_d  = 1'b0;
      sticky_d = 1'b0;
`endif
    end

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
  end

  // State and output registers; clear_bar aborts any scan immediately.
  always_ff @(posedge clk or negedge clear_bar) begin
    if (!clear_bar) begin
      state_q  <= ST_IDLE;
      select_q <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      enb_q    <= '1;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      enb_q    <= enb_d;
    end
  end

`ifdef MUX_SCAN_DOUBLE_SAMPLE_EN
  // Sample-phase and glitch-report registers.
  always_ff @(posedge clk or negedge clear_bar) begin
    if (!clear_bar) begin
      phase_q  <= 1'b0;
      sticky_q <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      sticky_q <= sticky_d;
      glitch_q <= glitch_d;
    end
  end

  assign glitch = glitch_q;
`else
  assign glitch = 1'b0;
`endif

  assign busy       = busy_q;
  assign select     = select_q;
  assign enable_bar = enb_q;
  assign data       = data_q;
  assign valid      = valid_q;
  assign dbg_state  = state_q;

endmodule
